// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher: fetches scanlines from frame memory into a double-banked line buffer
module vga_line_fetcher #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] frameBase,
  input  logic [9:0]  lineWords,
  input  logic        doubleScan,
  input  logic        lineRequest,
  input  logic        endOfFrame,
  output logic        memRead,
  output logic [21:0] memAddress,
  input  logic        memWaitRequest,
  input  logic        memReadDataValid,
  input  logic [31:0] memReadData,
  output logic        bufferWriteEnable,
  output logic [9:0]  bufferWriteAddress,
  output logic [31:0] bufferWriteData,
  output logic        readBank,
  output logic        busy,
  output logic        underrun
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam logic [2:0] MAX_PEND = 3'(MAX_PENDING);
  state_t state, state_next;
  logic [9:0] issued, received, words;
  logic [2:0] pending;
  logic [21:0] line_addr, fetch_addr;
  logic rep, restart_pending, hold, accept, ret, start, done;
  always_comb begin
    words = lineWords > 10'd512 ? 10'd512 : lineWords;
    memRead = state == FETCH ? issued < words && pending < MAX_PEND : state == DRAIN && hold;
    memAddress = fetch_addr;
    busy = state != IDLE;
    accept = memRead && !memWaitRequest;
    ret = memReadDataValid && pending != 3'd0;
    start = state == IDLE && !endOfFrame && (restart_pending || lineRequest);
    done = state == FETCH && received == words;
    state_next = state == IDLE ? (start ? FETCH : IDLE) :
                 state == FETCH ? (endOfFrame ? DRAIN : done ? IDLE : FETCH) :
                 (pending == 3'd0 && !memRead ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      issued <= '0;
      received <= '0;
      pending <= '0;
      line_addr <= '0;
      fetch_addr <= '0;
      rep <= 1'b0;
      restart_pending <= 1'b0;
      hold <= 1'b0;
      readBank <= 1'b0;
      underrun <= 1'b0;
      bufferWriteEnable <= 1'b0;
      bufferWriteAddress <= '0;
      bufferWriteData <= '0;
    end else begin
      state <= state_next;
      hold <= memRead && memWaitRequest;
      underrun <= lineRequest && busy && !endOfFrame;
      bufferWriteEnable <= state == FETCH && ret;
      pending <= pending + 3'(accept) - 3'(ret);
      if (state == FETCH && ret) begin
        bufferWriteAddress <= {~readBank, received[8:0]};
        bufferWriteData <= memReadData;
        received <= received + 10'd1;
      end
      if (accept) begin
        fetch_addr <= fetch_addr + 22'd1;
        issued <= issued + 10'd1;
      end
      if (start) begin
        fetch_addr <= line_addr;
        issued <= '0;
        received <= '0;
        pending <= '0;
        restart_pending <= 1'b0;
        readBank <= restart_pending ? readBank : ~readBank;
      end
      if (done) begin
        line_addr <= !doubleScan || rep ? line_addr + 22'(words) : line_addr;
        rep <= doubleScan && !rep;
      end
      if (endOfFrame) begin
        line_addr <= frameBase[23:2];
        rep <= 1'b0;
        restart_pending <= 1'b1;
      end
    end
  end
endmodule
